// File: rtl/me_pkg.sv
// Shared constants, derived stream geometry and FSM encoding for the frame feeder.
package me_pkg;

    localparam int unsigned MB_SIZE          = 16;
    localparam int unsigned FRAME_W_DEF      = 352;
    localparam int unsigned FRAME_H_DEF      = 288;
    localparam int unsigned SR_DEF           = 8;
    localparam int unsigned CUR_PIX_PER_WORD = 4;
    localparam int unsigned REF_PIX_PER_WORD = 8;
    localparam int unsigned CUR_AW           = 17;
    localparam int unsigned REF_AW           = 16;

    // Side length of the reference search window for a given search range.
    function automatic int unsigned win_dim(input int unsigned sr);
        return MB_SIZE + 2 * sr;
    endfunction

    localparam int unsigned CUR_BEATS_PER_ROW_DEF = MB_SIZE / CUR_PIX_PER_WORD;
    localparam int unsigned CUR_ROWS_DEF          = MB_SIZE;
    localparam int unsigned REF_ROWS_DEF          = win_dim(SR_DEF);
    localparam int unsigned REF_BEATS_PER_ROW_DEF = REF_ROWS_DEF / REF_PIX_PER_WORD;
    localparam int unsigned MBS_X_DEF             = FRAME_W_DEF / MB_SIZE;
    localparam int unsigned MBS_Y_DEF             = FRAME_H_DEF / MB_SIZE;
    localparam int unsigned MBS_DEF               = MBS_X_DEF * MBS_Y_DEF;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } feeder_state_e;

endpackage

// File: rtl/me_addr_gen.sv
// Raster MB / row / beat counters with a window-relative word address, optional edge clamp.
module me_addr_gen
    import me_pkg::*;
#(
    parameter int unsigned BEATS        = 4,
    parameter int unsigned ROWS         = 16,
    parameter int unsigned MBS_X        = 22,
    parameter int unsigned MBS_Y        = 18,
    parameter int unsigned MB_COL_WORDS = 4,
    parameter int unsigned LINE_WORDS   = 88,
    parameter int unsigned LINES        = 288,
    parameter int unsigned ROW_OFF      = 0,
    parameter int unsigned COL_OFF      = 0,
    parameter int unsigned AW           = 17,
    parameter bit          CLAMP        = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_adv,
    output logic [AW-1:0] o_addr,
    output logic          o_in_frame,
    output logic          o_last
);

    localparam int unsigned CW = 16;

    localparam logic [CW-2:0] BEAT_MAX = (CW-1)'(BEATS - 1);
    localparam logic [CW-2:0] ROW_MAX  = (CW-1)'(ROWS - 1);
    localparam logic [CW-2:0] MBX_MAX  = (CW-1)'(MBS_X - 1);
    localparam logic [CW-2:0] MBY_MAX  = (CW-1)'(MBS_Y - 1);

    localparam logic signed [CW-1:0] S_MB_ROWS   = CW'(MB_SIZE);
    localparam logic signed [CW-1:0] S_MB_COLS   = CW'(MB_COL_WORDS);
    localparam logic signed [CW-1:0] S_ROW_OFF   = CW'(ROW_OFF);
    localparam logic signed [CW-1:0] S_COL_OFF   = CW'(COL_OFF);
    localparam logic signed [CW-1:0] S_LINE_MAX  = CW'(LINES - 1);
    localparam logic signed [CW-1:0] S_WORD_MAX  = CW'(LINE_WORDS - 1);

    logic [CW-2:0] r_beat, r_row, r_mbx, r_mby;
    logic          w_beat_wrap, w_row_wrap, w_mbx_wrap;
    logic signed [CW-1:0] w_row, w_col, w_row_c, w_col_c;

    assign w_beat_wrap = (r_beat == BEAT_MAX);
    assign w_row_wrap  = w_beat_wrap && (r_row == ROW_MAX);
    assign w_mbx_wrap  = w_row_wrap && (r_mbx == MBX_MAX);
    assign o_last      = w_mbx_wrap && (r_mby == MBY_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat <= '0;
            r_row  <= '0;
            r_mbx  <= '0;
            r_mby  <= '0;
        end else if (i_adv) begin
            r_beat <= w_beat_wrap ? '0 : r_beat + 1'b1;
            if (w_beat_wrap) r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            if (w_row_wrap)  r_mbx <= w_mbx_wrap ? '0 : r_mbx + 1'b1;
            if (w_mbx_wrap)  r_mby <= o_last ? '0 : r_mby + 1'b1;
        end
    end

    // Window coordinates are signed: the search window overhangs the frame at the edges.
    assign w_row = $signed({1'b0, r_mby}) * S_MB_ROWS + $signed({1'b0, r_row}) - S_ROW_OFF;
    assign w_col = $signed({1'b0, r_mbx}) * S_MB_COLS + $signed({1'b0, r_beat}) - S_COL_OFF;

    assign o_in_frame = !w_row[CW-1] && (w_row <= S_LINE_MAX) &&
                        !w_col[CW-1] && (w_col <= S_WORD_MAX);

    always_comb begin
        w_row_c = w_row;
        w_col_c = w_col;
        if (CLAMP) begin
            if (w_row[CW-1])             w_row_c = '0;
            else if (w_row > S_LINE_MAX) w_row_c = S_LINE_MAX;
            if (w_col[CW-1])             w_col_c = '0;
            else if (w_col > S_WORD_MAX) w_col_c = S_WORD_MAX;
        end
    end

    assign o_addr = AW'(unsigned'(w_row_c)) * AW'(LINE_WORDS) + AW'(unsigned'(w_col_c));

endmodule

// File: rtl/frame_feeder.sv
// Streams current-MB and reference-window pixels from frame memories to a motion estimator.
// FEEDER_EDGE_CLAMP_EN: clamp out-of-frame ref reads to the frame edge instead of zero-filling.
module frame_feeder
    import me_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned FRAME_H = FRAME_H_DEF,
    parameter int unsigned SR      = SR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              need_cur,
    input  logic              need_ref,
    output logic [31:0]       cur_in,
    output logic [63:0]       ref_in,
    output logic              cur_mem_en,
    output logic [CUR_AW-1:0] cur_mem_addr,
    input  logic [31:0]       cur_mem_rdata,
    output logic              ref_mem_en,
    output logic [REF_AW-1:0] ref_mem_addr,
    input  logic [63:0]       ref_mem_rdata,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

`ifdef FEEDER_EDGE_CLAMP_EN
    localparam bit EDGE_CLAMP = 1'b1;
`else
    localparam bit EDGE_CLAMP = 1'b0;
`endif

    localparam int unsigned MBS_X   = FRAME_W / MB_SIZE;
    localparam int unsigned MBS_Y   = FRAME_H / MB_SIZE;
    localparam int unsigned CUR_BPR = MB_SIZE / CUR_PIX_PER_WORD;
    localparam int unsigned REF_WIN = win_dim(SR);
    localparam int unsigned REF_BPR = REF_WIN / REF_PIX_PER_WORD;

    feeder_state_e r_state;
    logic          r_busy, r_frame_done, r_err;
    logic          r_cur_done, r_ref_done;
    logic          r_cur_pend, r_ref_pend, r_ref_zero;
    logic [31:0]   r_cur_in;
    logic [63:0]   r_ref_in;

    logic              w_run, w_cur_ok, w_ref_ok, w_ref_rd;
    logic              w_cur_last, w_ref_last, w_cur_in_frame, w_ref_in_frame;
    logic              w_cur_done_nx, w_ref_done_nx;
    logic [CUR_AW-1:0] w_cur_addr;
    logic [REF_AW-1:0] w_ref_addr;

    assign w_run    = (r_state == StRun);
    assign w_cur_ok = need_cur && w_run && !r_cur_done && !rst;
    assign w_ref_ok = need_ref && w_run && !r_ref_done && !rst;
    // An accepted ref beat outside the frame still consumes a slot but reads nothing.
    assign w_ref_rd = w_ref_ok && (EDGE_CLAMP || w_ref_in_frame);

    assign w_cur_done_nx = r_cur_done || (w_cur_ok && w_cur_last);
    assign w_ref_done_nx = r_ref_done || (w_ref_ok && w_ref_last);

    me_addr_gen #(
        .BEATS        (CUR_BPR),
        .ROWS         (MB_SIZE),
        .MBS_X        (MBS_X),
        .MBS_Y        (MBS_Y),
        .MB_COL_WORDS (MB_SIZE / CUR_PIX_PER_WORD),
        .LINE_WORDS   (FRAME_W / CUR_PIX_PER_WORD),
        .LINES        (FRAME_H),
        .ROW_OFF      (0),
        .COL_OFF      (0),
        .AW           (CUR_AW),
        .CLAMP        (1'b0)
    ) u_cur_gen (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_adv      (w_cur_ok),
        .o_addr     (w_cur_addr),
        .o_in_frame (w_cur_in_frame),
        .o_last     (w_cur_last)
    );

    me_addr_gen #(
        .BEATS        (REF_BPR),
        .ROWS         (REF_WIN),
        .MBS_X        (MBS_X),
        .MBS_Y        (MBS_Y),
        .MB_COL_WORDS (MB_SIZE / REF_PIX_PER_WORD),
        .LINE_WORDS   (FRAME_W / REF_PIX_PER_WORD),
        .LINES        (FRAME_H),
        .ROW_OFF      (SR),
        .COL_OFF      (SR / REF_PIX_PER_WORD),
        .AW           (REF_AW),
        .CLAMP        (EDGE_CLAMP)
    ) u_ref_gen (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_adv      (w_ref_ok),
        .o_addr     (w_ref_addr),
        .o_in_frame (w_ref_in_frame),
        .o_last     (w_ref_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_cur_done   <= 1'b0;
            r_ref_done   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if ((need_cur && !w_cur_ok) || (need_ref && !w_ref_ok)) r_err <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StRun;
                        r_busy  <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_cur_done_nx && w_ref_done_nx) begin
                        r_state      <= StIdle;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_cur_done   <= 1'b0;
                        r_ref_done   <= 1'b0;
                    end else begin
                        r_cur_done <= w_cur_done_nx;
                        r_ref_done <= w_ref_done_nx;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_pend <= 1'b0;
            r_ref_pend <= 1'b0;
            r_ref_zero <= 1'b0;
            r_cur_in   <= '0;
            r_ref_in   <= '0;
        end else begin
            r_cur_pend <= w_cur_ok;
            r_ref_pend <= w_ref_ok;
            r_ref_zero <= !w_ref_rd;
            if (r_cur_pend) r_cur_in <= cur_mem_rdata;
            if (r_ref_pend) r_ref_in <= r_ref_zero ? '0 : ref_mem_rdata;
        end
    end

    assign cur_mem_en   = w_cur_ok && w_cur_in_frame;
    assign cur_mem_addr = w_cur_addr;
    assign ref_mem_en   = w_ref_rd;
    assign ref_mem_addr = w_ref_addr;
    assign cur_in       = r_cur_in;
    assign ref_in       = r_ref_in;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign err          = r_err;

endmodule
